am2940_sequencer: RTL and testbench
===================================

Name: am2940_sequencer

Overview:
Instruction-driven control and counter block for the Am2940 DMA address datapath. It decodes the 3-bit instruction each clock. It owns the control register, address register/counter and word register/counter. It drives the load-source selects of the shared 2:1 and 3:1 data muxes and generates done and carry outputs. It sits between the microprogram sequencer, which supplies instr and the data bus, and the memory address bus.

Parameters:
DATA_LENGTH, `DATA_LENGTH (8), width of data bus, address and word paths.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
instr  input  3  instruction code, sampled every rising clk
data_in  input  DATA_LENGTH  data bus input (load value / control word)
data_out  output  DATA_LENGTH  readback value
data_oe  output  1  high when data_out must drive the bus
aci_n  input  1  address count enable, active low
wci_n  input  1  word count enable, active low
addr_out  output  DATA_LENGTH  address counter value
aco_n  output  1  address counter carry/borrow out, active low
wco_n  output  1  word counter carry/borrow out, active low
done  output  1  transfer-complete flag

Behaviour:
- Reset (reset_n low, async): CR=3'b000, AR=AC=WR=WC=0. data_oe=0, data_out=0, done=0, aco_n=wco_n=1.
- CR[1:0] is the mode: 0 word count down; 1 word count up; 2 address compare; 3 word count up, free-running. CR[2]=0 increments AC, CR[2]=1 decrements AC.
- Instructions (opcodes in shared header), register effects at next rising clk:
  - 0 WRCR: CR<=data_in[2:0]. In modes 1/2/3 (new CR value) WC<=0.
  - 1 RDCR: data_out={ones, CR}, data_oe=1. No state change.
  - 2 RDWC: data_out=WC, data_oe=1.
  - 3 RDAC: data_out=AC, data_oe=1.
  - 4 REINIT: AC<=AR. Mode 0: WC<=WR; other modes: WC<=0.
  - 5 LDADDR: AR<=data_in, AC<=data_in.
  - 6 LDWC: WR<=data_in. Mode 0: WC<=data_in; other modes: WC<=0.
  - 7 ENCNT: if aci_n=0, AC steps per CR[2]. If wci_n=0 and mode!=2, WC steps: down in mode 0, up in modes 1/3. Mode 2 never counts WC.
- data_oe/data_out are combinational from instr (opcodes 1-3). data_oe=0 and data_out=0 otherwise.
- Counter load source is chosen through Mux2To1 (data_in vs AR for AC) and Mux3To1 (data_in / WR / zero for WC). Select encoding is owned by this block.
- Arithmetic is modulo 2^DATA_LENGTH; counters wrap silently (0xFF+1=0x00, 0x00-1=0xFF).
- aco_n=0 iff instr=7, aci_n=0 and AC is at terminal value (all ones when incrementing, zero when decrementing). Combinational.
- wco_n=0 iff instr=7, wci_n=0, mode!=2 and WC is at terminal value (zero in mode 0, all ones in modes 1/3).
- done, combinational from registered state:
  - mode 0: WC==1
  - mode 1: WC+1==WR
  - mode 2: AC==WR
  - mode 3: 0
- Counting is not inhibited by done; the microprogram stops issuing ENCNT.
- addr_out=AC continuously; latency from load/count instruction to addr_out is 1 clk.
- Reset mid-operation forces the reset values immediately, regardless of instr.
- Undefined/X on instr is not legal; no recovery logic.

Decomposition:
- Shared header (alongside Lengths.v): opcode defines (WRCR..ENCNT), mode encodings, mux select encodings for counter load sources.
- One sub-module, am2940_counter: DATA_LENGTH-wide loadable up/down counter with load, count_en, dir, terminal-count output. Instantiated twice (AC, WC).
- Load-value selection reuses the existing Mux2To1/Mux3To1.

Test Plan:
- Reset then RDCR → data_oe=1, data_out=8'hF8, addr_out=0, done=0.
- WRCR 3'b000, LDWC 8'h03, LDADDR 8'h10, three ENCNT with aci_n=wci_n=0 → addr_out 8'h11,8'h12,8'h13. WC 2,1,0; done=1 only while WC==1.
- WRCR 3'b100 (decrement), LDADDR 8'h00, ENCNT aci_n=0 → aco_n=0 during the cycle, addr_out wraps to 8'hFF next clk.
- WRCR 3'b001, LDWC 8'h04, ENCNT x3 → WC 0→3, done asserts when WC=3. REINIT → WC=0, AC=AR, done=0.
- WRCR 3'b010, LDWC 8'h20, LDADDR 8'h1E, ENCNT x2 → done=1 at AC=8'h20; WC stays 0 with wci_n=0.
- Assert reset_n low asynchronously mid-ENCNT burst → all outputs at reset values before next clk edge; counting resumes only after reset_n high and new loads.

Source files
------------

// File: rtl/am2940_sequencer_pkg.sv
// Shared definitions for the Am2940 sequencer: data width, opcodes, counter modes
// and the load-source select encodings for the shared data muxes.
package am2940_sequencer_pkg;

    localparam int unsigned DataLength = 8;

    typedef enum logic [2:0] {
        OpWrcr   = 3'd0,
        OpRdcr   = 3'd1,
        OpRdwc   = 3'd2,
        OpRdac   = 3'd3,
        OpReinit = 3'd4,
        OpLdaddr = 3'd5,
        OpLdwc   = 3'd6,
        OpEncnt  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ModeWordDown = 2'd0,
        ModeWordUp   = 2'd1,
        ModeAddrCmp  = 2'd2,
        ModeFreeRun  = 2'd3
    } mode_e;

    // Mux2To1 select for the address counter load value.
    typedef enum logic {
        AcSelData = 1'b0,
        AcSelAr   = 1'b1
    } ac_sel_e;

    // Mux3To1 select for the word counter load value.
    typedef enum logic [1:0] {
        WcSelData = 2'd0,
        WcSelWr   = 2'd1,
        WcSelZero = 2'd2
    } wc_sel_e;

endpackage

// File: rtl/am2940_counter.sv
// Loadable up/down counter with wrap-around; load has priority over counting.
module am2940_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             cnt_en_i,
    input  logic             dir_up_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (cnt_en_i) begin
            q_d = dir_up_i ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // Terminal value is the one that carries or borrows on the next step.
    assign tc_o = dir_up_i ? (&q_q) : ~(|q_q);
    assign q_o  = q_q;

endmodule

// File: rtl/mux2to1.sv
// Generic two-input data multiplexer.
module mux2to1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux3to1.sv
// Generic three-input data multiplexer; select 3 falls back to input c.
module mux3to1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] y_o
);

    always_comb begin
        y_o = c_i;
        case (sel_i)
            2'd0:    y_o = a_i;
            2'd1:    y_o = b_i;
            default: y_o = c_i;
        endcase
    end

endmodule

// File: rtl/am2940_sequencer.sv
// Am2940 control block: decodes the instruction, owns CR/AR/WR and the address
// and word counters, and produces readback, carry and done outputs.
module am2940_sequencer
    import am2940_sequencer_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = DataLength
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [2:0]             instr_i,
    input  logic [DATA_LENGTH-1:0] data_in_i,
    output logic [DATA_LENGTH-1:0] data_out_o,
    output logic                   data_oe_o,
    input  logic                   aci_ni,
    input  logic                   wci_ni,
    output logic [DATA_LENGTH-1:0] addr_out_o,
    output logic                   aco_no,
    output logic                   wco_no,
    output logic                   done_o
);

    op_e   op;
    mode_e mode;

    logic [2:0]             cr_d, cr_q;
    logic [DATA_LENGTH-1:0] ar_d, ar_q;
    logic [DATA_LENGTH-1:0] wr_d, wr_q;

    logic                   ac_load, wc_load;
    ac_sel_e                ac_sel;
    wc_sel_e                wc_sel;
    logic [DATA_LENGTH-1:0] ac_load_val, wc_load_val;
    logic [DATA_LENGTH-1:0] ac_q, wc_q;
    logic                   ac_tc, wc_tc;
    logic                   ac_cnt_en, wc_cnt_en;
    logic                   ac_up, wc_up;

    assign op   = op_e'(instr_i);
    assign mode = mode_e'(cr_q[1:0]);

    always_comb begin
        ac_load = 1'b0;
        ac_sel  = AcSelData;
        wc_load = 1'b0;
        wc_sel  = WcSelZero;
        unique case (op)
            // A new non-word-down mode restarts the word count from zero.
            OpWrcr: wc_load = (data_in_i[1:0] != ModeWordDown);
            OpReinit: begin
                ac_load = 1'b1;
                ac_sel  = AcSelAr;
                wc_load = 1'b1;
                wc_sel  = (mode == ModeWordDown) ? WcSelWr : WcSelZero;
            end
            OpLdaddr: begin
                ac_load = 1'b1;
                ac_sel  = AcSelData;
            end
            OpLdwc: begin
                wc_load = 1'b1;
                wc_sel  = (mode == ModeWordDown) ? WcSelData : WcSelZero;
            end
            default: ;
        endcase
    end

    always_comb begin
        cr_d = cr_q;
        ar_d = ar_q;
        wr_d = wr_q;
        if (op == OpWrcr)   cr_d = data_in_i[2:0];
        if (op == OpLdaddr) ar_d = data_in_i;
        if (op == OpLdwc)   wr_d = data_in_i;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cr_q <= '0;
            ar_q <= '0;
            wr_q <= '0;
        end else begin
            cr_q <= cr_d;
            ar_q <= ar_d;
            wr_q <= wr_d;
        end
    end

    mux2to1 #(
        .WIDTH (DATA_LENGTH)
    ) u_ac_mux (
        .sel_i (ac_sel == AcSelAr),
        .a_i   (data_in_i),
        .b_i   (ar_q),
        .y_o   (ac_load_val)
    );

    mux3to1 #(
        .WIDTH (DATA_LENGTH)
    ) u_wc_mux (
        .sel_i (wc_sel),
        .a_i   (data_in_i),
        .b_i   (wr_q),
        .c_i   ('0),
        .y_o   (wc_load_val)
    );

    assign ac_up     = ~cr_q[2];
    assign wc_up     = (mode != ModeWordDown);
    assign ac_cnt_en = (op == OpEncnt) && !aci_ni;
    assign wc_cnt_en = (op == OpEncnt) && !wci_ni && (mode != ModeAddrCmp);

    am2940_counter #(
        .WIDTH (DATA_LENGTH)
    ) u_ac (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .load_i     (ac_load),
        .load_val_i (ac_load_val),
        .cnt_en_i   (ac_cnt_en),
        .dir_up_i   (ac_up),
        .q_o        (ac_q),
        .tc_o       (ac_tc)
    );

    am2940_counter #(
        .WIDTH (DATA_LENGTH)
    ) u_wc (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .load_i     (wc_load),
        .load_val_i (wc_load_val),
        .cnt_en_i   (wc_cnt_en),
        .dir_up_i   (wc_up),
        .q_o        (wc_q),
        .tc_o       (wc_tc)
    );

    // Outputs are held at their reset values while reset is asserted, whatever instr is.
    always_comb begin
        data_oe_o  = 1'b0;
        data_out_o = '0;
        if (reset_ni) begin
            case (op)
                OpRdcr: begin
                    data_oe_o  = 1'b1;
                    data_out_o = {{(DATA_LENGTH-3){1'b1}}, cr_q};
                end
                OpRdwc: begin
                    data_oe_o  = 1'b1;
                    data_out_o = wc_q;
                end
                OpRdac: begin
                    data_oe_o  = 1'b1;
                    data_out_o = ac_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        done_o = 1'b0;
        unique case (mode)
            ModeWordDown: done_o = (wc_q == DATA_LENGTH'(1));
            ModeWordUp:   done_o = ((wc_q + DATA_LENGTH'(1)) == wr_q);
            ModeAddrCmp:  done_o = (ac_q == wr_q);
            ModeFreeRun:  done_o = 1'b0;
            default:      done_o = 1'b0;
        endcase
    end

    assign aco_no     = ~(reset_ni && ac_cnt_en && ac_tc);
    assign wco_no     = ~(reset_ni && wc_cnt_en && wc_tc);
    assign addr_out_o = ac_q;

endmodule

// File: tb/tb_am2940_sequencer.sv
// Randomized scoreboard bench for am2940_sequencer against a register-level model.
module tb_am2940_sequencer;

    localparam int DL = 8;
    localparam int MASK = (1 << DL) - 1;

    logic          clk;
    logic          reset_n;
    logic [2:0]    instr;
    logic [DL-1:0] data_in;
    logic [DL-1:0] data_out;
    logic          data_oe;
    logic          aci_n;
    logic          wci_n;
    logic [DL-1:0] addr_out;
    logic          aco_n;
    logic          wco_n;
    logic          done;

    am2940_sequencer #(
        .DATA_LENGTH (DL)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .instr_i    (instr),
        .data_in_i  (data_in),
        .data_out_o (data_out),
        .data_oe_o  (data_oe),
        .aci_ni     (aci_n),
        .wci_ni     (wci_n),
        .addr_out_o (addr_out),
        .aco_no     (aco_n),
        .wco_no     (wco_n),
        .done_o     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int oe;
        int dout;
        int addr;
        int aco_n;
        int wco_n;
        int done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: plain integers, modulo 2^DL.
    int m_cr, m_ar, m_wr, m_ac, m_wc;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cr = 0; m_ar = 0; m_wr = 0; m_ac = 0; m_wc = 0;
    endfunction

    function automatic exp_t model_expect(input int ins, input int aci, input int wci);
        exp_t e;
        int   mode = m_cr % 4;
        int   ac_term = (m_cr >= 4) ? 0 : MASK;
        int   wc_term = (mode == 0) ? 0 : MASK;
        e.oe   = (ins >= 1 && ins <= 3) ? 1 : 0;
        e.dout = (ins == 1) ? (MASK - 7 + m_cr) : (ins == 2) ? m_wc : (ins == 3) ? m_ac : 0;
        e.addr = m_ac;
        e.aco_n = (ins == 7 && aci == 0 && m_ac == ac_term) ? 0 : 1;
        e.wco_n = (ins == 7 && wci == 0 && mode != 2 && m_wc == wc_term) ? 0 : 1;
        if (mode == 0)      e.done = (m_wc == 1) ? 1 : 0;
        else if (mode == 1) e.done = (((m_wc + 1) & MASK) == m_wr) ? 1 : 0;
        else if (mode == 2) e.done = (m_ac == m_wr) ? 1 : 0;
        else                e.done = 0;
        return e;
    endfunction

    function automatic void model_update(input int ins, input int d, input int aci, input int wci);
        int mode = m_cr % 4;
        case (ins)
            0: begin
                m_cr = d & 7;
                if ((m_cr % 4) != 0) m_wc = 0;
            end
            4: begin
                m_ac = m_ar;
                m_wc = (mode == 0) ? m_wr : 0;
            end
            5: begin
                m_ar = d;
                m_ac = d;
            end
            6: begin
                m_wr = d;
                m_wc = (mode == 0) ? d : 0;
            end
            7: begin
                if (aci == 0) m_ac = (m_cr >= 4) ? ((m_ac - 1) & MASK) : ((m_ac + 1) & MASK);
                if (wci == 0 && mode != 2)
                    m_wc = (mode == 0) ? ((m_wc - 1) & MASK) : ((m_wc + 1) & MASK);
            end
            default: ;
        endcase
    endfunction

    task automatic step(input int ins, input int d, input int aci, input int wci);
        @(posedge clk);
        #1;
        instr   = 3'(ins);
        data_in = DL'(d);
        aci_n   = aci[0];
        wci_n   = wci[0];
        sb_q.push_back(model_expect(ins, aci, wci));
        model_update(ins, d & MASK, aci, wci);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("data_oe", int'(data_oe), e.oe);
                check("data_out", int'(data_out), e.dout);
                check("addr_out", int'(addr_out), e.addr);
                check("aco_n", int'(aco_n), e.aco_n);
                check("wco_n", int'(wco_n), e.wco_n);
                check("done", int'(done), e.done);
            end
        end
    end

    initial begin : stimulus
        int d;
        int waited;
        reset_n = 1'b0;
        instr   = 3'd0;
        data_in = '0;
        aci_n   = 1'b1;
        wci_n   = 1'b1;
        model_reset();
        #22;
        reset_n = 1'b1;

        step(1, 0, 1, 1);
        // Mode 0 word count down with address increment.
        step(0, 8'h00, 1, 1);
        step(6, 8'h03, 1, 1);
        step(5, 8'h10, 1, 1);
        repeat (3) step(7, 0, 0, 0);
        step(2, 0, 1, 1);
        step(3, 0, 1, 1);
        // Decrement wrap with borrow.
        step(0, 8'h04, 1, 1);
        step(5, 8'h00, 1, 1);
        step(7, 0, 0, 1);
        step(3, 0, 1, 1);
        // Mode 1 word count up, then reinit.
        step(0, 8'h01, 1, 1);
        step(6, 8'h04, 1, 1);
        repeat (3) step(7, 0, 0, 0);
        step(4, 0, 1, 1);
        step(2, 0, 1, 1);
        // Mode 2 address compare; WC must not move.
        step(0, 8'h02, 1, 1);
        step(6, 8'h20, 1, 1);
        step(5, 8'h1E, 1, 1);
        repeat (2) step(7, 0, 0, 0);
        step(2, 0, 1, 1);
        // Mode 3 free-running up counter.
        step(0, 8'h03, 1, 1);
        repeat (4) step(7, 0, 0, 0);
        step(2, 0, 1, 1);

        // Asynchronous reset in the middle of a counting burst.
        step(0, 8'h00, 1, 1);
        step(6, 8'h05, 1, 1);
        step(5, 8'h40, 1, 1);
        repeat (2) step(7, 0, 0, 0);
        @(posedge clk);
        #1;
        instr = 3'd7; aci_n = 1'b0; wci_n = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_addr_out", int'(addr_out), 0);
        check("rst_aco_n", int'(aco_n), 1);
        check("rst_wco_n", int'(wco_n), 1);
        check("rst_done", int'(done), 0);
        check("rst_data_oe", int'(data_oe), 0);
        instr = 3'd1;
        #1;
        check("rst_rdcr_oe", int'(data_oe), 0);
        check("rst_rdcr_out", int'(data_out), 0);
        @(posedge clk);
        #1;
        check("rst_hold_addr", int'(addr_out), 0);
        reset_n = 1'b1;
        step(1, 0, 1, 1);
        step(5, 8'h77, 1, 1);
        step(7, 0, 0, 0);
        step(3, 0, 1, 1);

        // Randomized traffic, biased towards wrap-prone values.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 5))
                0:       d = 0;
                1:       d = 1;
                2:       d = MASK;
                3:       d = MASK - 1;
                default: d = int'($urandom_range(0, MASK));
            endcase
            step(int'($urandom_range(0, 7)), d, int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)));
        end

        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
